// File: rtl/ras_ckpt.sv
// Return address stack for fetch with checkpoint slots, so that the stack can be
// rolled back to the state a predicted branch saw when that branch mispredicts.
module ras_ckpt #(
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32,
  parameter int NUM_CKPT = 4,
  parameter int PC_INC   = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CNTW    = AW + 1,
  localparam int CW      = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_en,
  input  logic [XLEN-1:0]     push_pc,
  input  logic                pop_en,
  input  logic                ckpt_req,
  output logic                ckpt_gnt,
  output logic [CW-1:0]       ckpt_id,
  input  logic                restore_en,
  input  logic [CW-1:0]       restore_id,
  input  logic [NUM_CKPT-1:0] release_mask,
  output logic [XLEN-1:0]     top_pc,
  output logic                valid_out,
  output logic [CNTW-1:0]     count_out,
  output logic                ckpt_avail
);

  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [XLEN-1:0] INC  = XLEN'(PC_INC);

  logic [XLEN-1:0]     stack_q [DEPTH];
  logic [AW-1:0]       tail_q, tail_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [NUM_CKPT-1:0] busy_q, busy_d;
  logic [AW-1:0]       sv_tail_q  [NUM_CKPT];
  logic [CNTW-1:0]     sv_count_q [NUM_CKPT];
  logic [XLEN-1:0]     sv_top_q   [NUM_CKPT];

  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic [XLEN-1:0]     wr_data;
  logic [AW-1:0]       top_idx;
  logic [XLEN-1:0]     push_addr;
  logic [CW-1:0]       free_id;
  logic                not_empty;

  assign top_idx    = tail_q - 1'b1;
  assign push_addr  = push_pc + INC;
  assign not_empty  = (count_q != '0);

  assign top_pc     = stack_q[top_idx];
  assign valid_out  = not_empty;
  assign count_out  = count_q;
  assign ckpt_avail = ~&busy_q;

  // Lowest-index free slot; only meaningful while ckpt_avail is high.
  always_comb begin
    free_id = '0;
    for (int i = NUM_CKPT - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_id = CW'(i);
    end
  end

  assign ckpt_gnt = ckpt_req & ckpt_avail & ~restore_en;
  assign ckpt_id  = free_id;

  always_comb begin
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = tail_q;
    wr_data = push_addr;
    if (restore_en) begin
      tail_d  = sv_tail_q[restore_id];
      count_d = sv_count_q[restore_id];
      // Wrong-path push+pop may have clobbered the saved top entry; put it back.
      if (sv_count_q[restore_id] != '0) begin
        wr_en   = 1'b1;
        wr_idx  = sv_tail_q[restore_id] - 1'b1;
        wr_data = sv_top_q[restore_id];
      end
    end else if (push_en && pop_en && not_empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_en) begin
      wr_en  = 1'b1;
      tail_d = tail_q + 1'b1;
      if (count_q != FULL) count_d = count_q + 1'b1;
    end else if (pop_en && not_empty) begin
      tail_d  = tail_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // Grant is applied last so a same-cycle grant beats a release of that slot.
  always_comb begin
    busy_d = busy_q & ~release_mask;
    if (restore_en) busy_d[restore_id] = 1'b0;
    if (ckpt_gnt)   busy_d[free_id]    = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stack_q    <= '{default: '0};
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      sv_tail_q  <= '{default: '0};
      sv_count_q <= '{default: '0};
      sv_top_q   <= '{default: '0};
    end else begin
      if (wr_en) stack_q[wr_idx] <= wr_data;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      if (ckpt_gnt) begin
        sv_tail_q[free_id]  <= tail_q;
        sv_count_q[free_id] <= count_q;
        sv_top_q[free_id]   <= stack_q[top_idx];
      end
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt (default parameters): push/pop, overflow wrap,
// checkpoint grant/release, restore with top repair, restore priority and reset.
module tb_ras_ckpt;

  logic        clock;
  logic        reset;
  logic        push_en;
  logic [31:0] push_pc;
  logic        pop_en;
  logic        ckpt_req;
  logic        ckpt_gnt;
  logic [1:0]  ckpt_id;
  logic        restore_en;
  logic [1:0]  restore_id;
  logic [3:0]  release_mask;
  logic [31:0] top_pc;
  logic        valid_out;
  logic [3:0]  count_out;
  logic        ckpt_avail;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [3:0] mbusy = '0;

  ras_ckpt dut (
    .clock(clock), .reset(reset), .push_en(push_en), .push_pc(push_pc),
    .pop_en(pop_en), .ckpt_req(ckpt_req), .ckpt_gnt(ckpt_gnt), .ckpt_id(ckpt_id),
    .restore_en(restore_en), .restore_id(restore_id), .release_mask(release_mask),
    .top_pc(top_pc), .valid_out(valid_out), .count_out(count_out),
    .ckpt_avail(ckpt_avail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    push_en = 0; pop_en = 0; ckpt_req = 0; restore_en = 0; release_mask = '0;
  endtask

  task automatic do_push(input logic [31:0] pc);
    push_en = 1; push_pc = pc; cyc();
  endtask

  task automatic do_pop();
    pop_en = 1; cyc();
  endtask

  task automatic do_ckpt(input string tag, input logic [1:0] exp_id);
    ckpt_req = 1; #1;
    chk({tag, "_gnt"}, 32'(ckpt_gnt), 32'd1);
    chk({tag, "_id"}, 32'(ckpt_id), 32'(exp_id));
    mbusy[exp_id] = 1'b1;
    cyc();
  endtask

  task automatic do_restore(input logic [1:0] id);
    assert (mbusy[id] === 1'b1)
    else $error("FAIL restore_legal: slot %0d restored while free", id);
    mbusy[id] = 1'b0;
    restore_en = 1; restore_id = id; cyc();
  endtask

  initial begin
    reset = 1; push_en = 0; push_pc = '0; pop_en = 0; ckpt_req = 0;
    restore_en = 0; restore_id = '0; release_mask = '0;
    cyc();
    reset = 0;
    chk("rst_top", top_pc, 32'h0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_avail", 32'(ckpt_avail), 32'd1);

    // basic push/pop
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    chk("p3_top", top_pc, 32'h304);
    chk("p3_count", 32'(count_out), 32'd3);
    do_pop();
    chk("pop1_top", top_pc, 32'h204);
    do_pop();
    chk("pop2_top", top_pc, 32'h104);
    do_pop();
    chk("pop3_valid", 32'(valid_out), 32'd0);
    do_pop();
    chk("pop_empty_count", 32'(count_out), 32'd0);

    // overflow: ten calls into eight entries, oldest two lost
    for (int i = 0; i < 10; i++) do_push(32'(i * 4));
    chk("ovf_count", 32'(count_out), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf_pop%0d_top", k), top_pc, 32'h28 - 32'(k * 4));
      do_pop();
    end
    chk("ovf_empty_count", 32'(count_out), 32'd0);

    // snapshot taken with a same-cycle push saves the pre-push (empty) state
    push_en = 1; push_pc = 32'h100;
    do_ckpt("s3_ckpt", 2'd0);
    do_push(32'h500);
    do_pop();
    push_en = 1; pop_en = 1; push_pc = 32'h900; cyc();
    chk("s3_pp_top", top_pc, 32'h904);
    chk("s3_pp_count", 32'(count_out), 32'd1);
    do_restore(2'd0);
    chk("s3_rst_count", 32'(count_out), 32'd0);
    chk("s3_rst_valid", 32'(valid_out), 32'd0);
    chk("s3_rst_avail", 32'(ckpt_avail), 32'd1);

    // restore repairs a wrong-path overwrite of the top entry
    do_push(32'h100); do_push(32'h200);
    do_ckpt("s4_ckpt", 2'd0);
    do_pop();
    do_push(32'h700);
    chk("s4_wp_top", top_pc, 32'h704);
    do_restore(2'd0);
    chk("s4_rst_top", top_pc, 32'h204);
    chk("s4_rst_count", 32'(count_out), 32'd2);

    // exhaust the pool, then release one slot
    for (int s = 0; s < 4; s++) do_ckpt($sformatf("pool%0d", s), 2'(s));
    chk("pool_avail", 32'(ckpt_avail), 32'd0);
    ckpt_req = 1; #1;
    chk("pool_full_gnt", 32'(ckpt_gnt), 32'd0);
    cyc();
    release_mask = 4'b0100; ckpt_req = 1; #1;
    chk("rel_same_cycle_gnt", 32'(ckpt_gnt), 32'd0);
    mbusy[2] = 1'b0;
    cyc();
    chk("rel_avail", 32'(ckpt_avail), 32'd1);
    do_ckpt("rel_regrant", 2'd2);
    chk("rel_avail_again", 32'(ckpt_avail), 32'd0);

    // restore beats push and ckpt_req
    release_mask = 4'b0001; mbusy[0] = 1'b0; cyc();
    do_ckpt("pri_ckpt", 2'd0);
    do_push(32'h800);
    chk("pri_pre_top", top_pc, 32'h804);
    chk("pri_pre_count", 32'(count_out), 32'd3);
    push_en = 1; push_pc = 32'h900; ckpt_req = 1;
    restore_en = 1; restore_id = 2'd0; #1;
    chk("pri_gnt", 32'(ckpt_gnt), 32'd0);
    mbusy[0] = 1'b0;
    cyc();
    chk("pri_top", top_pc, 32'h204);
    chk("pri_count", 32'(count_out), 32'd2);
    chk("pri_avail", 32'(ckpt_avail), 32'd1);

    // reset overrides a concurrent restore and push
    do_push(32'hA00);
    reset = 1; restore_en = 1; restore_id = 2'd1; push_en = 1; push_pc = 32'hB00;
    cyc();
    reset = 0; mbusy = '0;
    chk("rst2_top", top_pc, 32'h0);
    chk("rst2_valid", 32'(valid_out), 32'd0);
    chk("rst2_count", 32'(count_out), 32'd0);
    chk("rst2_avail", 32'(ckpt_avail), 32'd1);
    ckpt_req = 1; #1;
    chk("rst2_first_id", 32'(ckpt_id), 32'd0);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
